fifo_sync_prog: RTL and testbench

// - Single-clock, parametrised FIFO; next generation of the bridge's dual-clock fifo_top.
// - Adds: registered-read or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_regfile.sv | 33 +++
 rtl/fifo_sync_prog.sv | 161 ++++++++++++++++
 tb/tb_fifo_sync_prog.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared types, default sizes and pointer-width helper for the FIFO
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  typedef enum logic {
    FIFO_REG  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int c_default_width = 8;
  localparam int c_default_depth = 16;

  // One extra MSB lets equal indices distinguish full from empty
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_regfile.sv
// ============================================================================
// fifo_regfile : DEPTH x WIDTH flop array, synchronous write, async read port
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; control logic tracks validity
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : fifo_regfile

`default_nettype wire

// File: rtl/fifo_sync_prog.sv
// ============================================================================
// fifo_sync_prog : single-clock FIFO, registered or FWFT read, programmable
//                  almost-full/empty, occupancy, flush and sticky errors
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_default_width,
  parameter int FIFO_DEPTH = c_default_depth,
  parameter int FWFT       = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              wen,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              ren,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              rvalid,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_space,
  input  logic [$clog2(FIFO_DEPTH):0]       af_thresh,
  input  logic [$clog2(FIFO_DEPTH):0]       ae_thresh,
  output logic                              almost_full,
  output logic                              almost_empty,
  input  logic                              err_clr,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             c_pw    = ptr_width(FIFO_DEPTH);
  localparam logic [c_pw-1:0] c_depth = c_pw'(FIFO_DEPTH);
  localparam fifo_mode_e     c_mode  = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;

  logic [c_pw-1:0]       r_wr_ptr;
  logic [c_pw-1:0]       r_rd_ptr;
  logic [c_pw-1:0]       r_count;
  logic [c_pw-1:0]       r_space;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [c_pw-1:0]       w_count_nxt;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Flush masks both requests, so a flushed cycle neither moves data nor flags errors
  assign w_wr_acc  = wen && !r_full  && !flush;
  assign w_rd_acc  = ren && !r_empty && !flush;
  assign w_ovf_set = wen &&  r_full  && !flush;
  assign w_unf_set = ren &&  r_empty && !flush;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + c_pw'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - c_pw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_space  <= c_depth;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_space  <= c_depth;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_pw'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_pw'(1);
      end
      r_count <= w_count_nxt;
      r_space <= c_depth - w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Sticky errors: a new offence in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set || (r_overflow  && !err_clr);
      r_underflow <= w_unf_set || (r_underflow && !err_clr);
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_mem_rdata)
  );

  generate
    if (c_mode == FIFO_FWFT) begin : g_fwft
      assign rdata  = w_mem_rdata;
      assign rvalid = !r_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rdata;
      logic                  r_rvalid;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rdata <= w_mem_rdata;
          end
        end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
    end
  endgenerate

  assign fifo_full    = r_full;
  assign fifo_empty   = r_empty;
  assign fifo_count   = r_count;
  assign fifo_space   = r_space;
  assign almost_full  = (af_thresh != '0) && (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule : fifo_sync_prog

`default_nettype wire

// File: tb/tb_fifo_sync_prog.sv
// ============================================================================
// tb_fifo_sync_prog : directed self-checking bench, registered and FWFT copies
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync_prog;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, wen, ren, err_clr;
  logic [DW-1:0] wdata;
  logic [AW:0]   af_thresh, ae_thresh;

  logic [DW-1:0] r_rdata, f_rdata;
  logic          r_rvalid, f_rvalid, r_full, f_full, r_empty, f_empty;
  logic [AW:0]   r_count, f_count, r_space, f_space;
  logic          r_af, f_af, r_ae, f_ae, r_ovf, f_ovf, r_unf, f_unf;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_dut_reg (
    .clk(clk), .reset(reset), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(r_rdata), .rvalid(r_rvalid), .fifo_full(r_full), .fifo_empty(r_empty),
    .fifo_count(r_count), .fifo_space(r_space), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(r_af), .almost_empty(r_ae), .err_clr(err_clr),
    .overflow(r_ovf), .underflow(r_unf)
  );

  fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_dut_fwft (
    .clk(clk), .reset(reset), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(f_rdata), .rvalid(f_rvalid), .fifo_full(f_full), .fifo_empty(f_empty),
    .fifo_count(f_count), .fifo_space(f_space), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(f_af), .almost_empty(f_ae), .err_clr(err_clr),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic w, r, acc_w, acc_r;
    logic [DW-1:0] exp_rd;

    reset = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; err_clr = 1'b0;
    wdata = '0; af_thresh = '0; ae_thresh = '0;
    repeat (3) tick();
    check("rst_empty", r_empty, 1);
    check("rst_full", r_full, 0);
    check("rst_count", r_count, 0);
    check("rst_space", r_space, 16);
    check("rst_rdata", r_rdata, 0);
    check("rst_rvalid", r_rvalid, 0);
    check("rst_ovf", r_ovf, 0);
    check("rst_unf", r_unf, 0);
    check("rst_ae", r_ae, 1);
    check("rst_af", r_af, 0);
    check("rst_fwft_rvalid", f_rvalid, 0);
    reset = 1'b0;

    // Single word, registered read latency
    wen = 1'b1; wdata = 8'hA5; tick();
    wen = 1'b0; ren = 1'b1;
    check("a5_count", r_count, 1);
    check("a5_fwft_rvalid", f_rvalid, 1);
    check("a5_fwft_rdata", f_rdata, 8'hA5);
    tick(); ren = 1'b0;
    check("a5_rdata", r_rdata, 8'hA5);
    check("a5_rvalid", r_rvalid, 1);
    check("a5_empty", r_empty, 1);
    tick();
    check("a5_rvalid_drop", r_rvalid, 0);

    // Fill, overflow, drain, underflow, clear
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = DW'(i); tick();
    end
    check("fill_full", r_full, 1);
    check("fill_space", r_space, 0);
    check("fill_ovf_clear", r_ovf, 0);
    wdata = 8'hFF;
    repeat (4) tick();
    wen = 1'b0;
    check("ovf_set", r_ovf, 1);
    check("ovf_count", r_count, 16);
    for (int i = 0; i < 16; i++) begin
      ren = 1'b1; tick();
      check("drain_data", r_rdata, i);
      check("drain_rvalid", r_rvalid, 1);
    end
    check("drain_unf_clear", r_unf, 0);
    tick(); ren = 1'b0;
    check("unf_set", r_unf, 1);
    check("unf_rvalid", r_rvalid, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_ovf", r_ovf, 0);
    check("clr_unf", r_unf, 0);

    // Simultaneous push/pop at count 5, then model-checked traffic across wrap
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; wdata = 8'h40 + DW'(i); tick(); q.push_back(wdata);
    end
    wen = 1'b1; ren = 1'b1; wdata = 8'h50; tick();
    exp_rd = q.pop_front(); q.push_back(8'h50);
    check("both_count", r_count, 5);
    check("both_rdata", r_rdata, exp_rd);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      wen = w; ren = r; wdata = DW'($urandom);
      acc_w = w && (q.size() < DEPTH);
      acc_r = r && (q.size() > 0);
      exp_rd = acc_r ? q[0] : '0;
      tick();
      if (acc_r) begin
        void'(q.pop_front());
        check("wrap_rdata", r_rdata, exp_rd);
      end
      if (acc_w) q.push_back(wdata);
      check("wrap_count", r_count, q.size());
      check("wrap_space", r_space, DEPTH - q.size());
      if (q.size() > 0) check("wrap_fwft_head", f_rdata, q[0]);
    end
    wen = 1'b0; ren = 1'b0;

    // Thresholds
    flush = 1'b1; err_clr = 1'b1; tick(); flush = 1'b0; err_clr = 1'b0;
    af_thresh = 5'd12; ae_thresh = 5'd2; #1;
    check("thr_ae_at0", r_ae, 1);
    for (int k = 1; k <= 16; k++) begin
      wen = 1'b1; wdata = DW'(k); tick();
      check("thr_af_up", r_af, (k >= 12));
      check("thr_ae_up", r_ae, (k <= 2));
    end
    wen = 1'b0;
    for (int k = 15; k >= 11; k--) begin
      ren = 1'b1; tick();
      check("thr_af_down", r_af, (k >= 12));
    end
    ren = 1'b0;
    af_thresh = 5'd0;
    wen = 1'b1; repeat (5) tick(); wen = 1'b0;
    check("af0_full", r_full, 1);
    check("af0_af", r_af, 0);

    // Flush with a concurrent write
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wen = 1'b1; wdata = 8'h60 + DW'(i); tick();
    end
    check("pre_flush_count", r_count, 7);
    flush = 1'b1; wen = 1'b1; wdata = 8'h11; tick();
    flush = 1'b0; wen = 1'b0;
    check("flush_count", r_count, 0);
    check("flush_empty", r_empty, 1);
    check("flush_ovf", r_ovf, 0);
    check("flush_unf", r_unf, 0);
    check("flush_fwft_rvalid", f_rvalid, 0);

    // FWFT show-ahead
    wen = 1'b1; wdata = 8'h3C; tick(); wen = 1'b0;
    check("fwft_rvalid", f_rvalid, 1);
    check("fwft_rdata", f_rdata, 8'h3C);
    tick();
    check("fwft_hold_rvalid", f_rvalid, 1);
    check("fwft_hold_rdata", f_rdata, 8'h3C);
    ren = 1'b1; tick(); ren = 1'b0;
    check("fwft_pop_rvalid", f_rvalid, 0);
    check("fwft_pop_empty", f_empty, 1);
    check("reg_pop_rdata", r_rdata, 8'h3C);

    // Reset mid-operation drops contents and the in-flight read
    wen = 1'b1; wdata = 8'h77; tick(); wen = 1'b0;
    ren = 1'b1; reset = 1'b1; tick(); reset = 1'b0; ren = 1'b0;
    check("mid_rst_count", r_count, 0);
    check("mid_rst_rvalid", r_rvalid, 0);
    check("mid_rst_rdata", r_rdata, 0);
    check("mid_rst_fwft_rvalid", f_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fifo_sync_prog

`default_nettype wire
